// File: rtl/l1_refill_responder.sv
// Backing-memory responder for the L1 refill/store-through path: one request at a time,
// fixed access latency, byte/halfword/word write merging, whole-word responses.
module l1_refill_responder #(
  parameter int ADDR_W  = 10,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_mask,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err
);

  localparam int IDX_W = ADDR_W - 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [1:0]        off_q, off_d;
  logic [2:0]        mask_q, mask_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [31:0]       mem_q [DEPTH];
  logic              mem_we_s;
  logic [31:0]       old_word_s;
  logic [31:0]       merged_s;
  logic              merge_ok_s;

  // Returns {supported, merged_word}; unsupported masks leave the word untouched.
  function automatic logic [32:0] merge_word(input logic [31:0] old_w,
                                             input logic [31:0] wd,
                                             input logic [2:0]  mask,
                                             input logic [1:0]  off);
    logic [31:0] w;
    logic        ok;
    w  = old_w;
    ok = 1'b1;
    case (mask)
      3'b000:  w[{off, 3'b000} +: 8] = wd[7:0];
      3'b001: begin
        if (off[1]) begin
          w[31:16] = wd[15:0];
        end else begin
          w[15:0] = wd[15:0];
        end
      end
      3'b010:  w = wd;
      default: ok = 1'b0;
    endcase
    return {ok, w};
  endfunction

  assign old_word_s               = mem_q[idx_q];
  assign {merge_ok_s, merged_s}   = merge_word(old_word_s, wdata_q, mask_q, off_q);

  assign req_ready  = (state_q == S_IDLE) && !reset;
  assign resp_valid = (state_q == S_RESP) && !reset;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  // Next-state, request latch and access decision.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    idx_d    = idx_q;
    off_d    = off_q;
    mask_d   = mask_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    mem_we_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          we_d    = req_we;
          idx_d   = req_addr[ADDR_W-1:2];
          off_d   = req_addr[1:0];
          mask_d  = req_mask;
          wdata_d = req_wdata;
          cnt_d   = 4'(LATENCY - 1);
          state_d = S_WAIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = S_RESP;
          if (!we_q) begin
            rdata_d = old_word_s;
            err_d   = 1'b0;
          end else if (merge_ok_s) begin
            rdata_d  = merged_s;
            err_d    = 1'b0;
            mem_we_s = 1'b1;
          end else begin
            rdata_d = old_word_s;
            err_d   = 1'b1;
          end
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and response registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      off_q   <= 2'd0;
      mask_q  <= 3'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      off_q   <= off_d;
      mask_q  <= mask_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Word array; reset clears every entry so an abandoned write can never land.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 32'd0;
      end
    end else if (mem_we_s) begin
      mem_q[idx_q] <= merged_s;
    end
  end

endmodule
